ls194_load_sequencer: RTL and testbench

// Upstream control stage for the ls194 pixel shift chain in the video path.
// - Buffers video bytes from the fetch logic over a valid/ready handshake.
// - Drives parallel-load data, mode selects (s1/s0) and serial-in bits so the

---
 rtl/video_pkg.sv | 20 ++
 rtl/byte_fifo.sv | 72 +++++++
 rtl/ls194_load_sequencer.sv | 113 +++++++++++
 tb/tb_ls194_load_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared types and default sizing for the ls194 pixel shift chain control path.
// Mode encodings match the ls194 s1/s0 select pins.
package video_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DOTS       = 7;
  localparam int DEF_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b10,
    MODE_LOAD = 2'b11
  } ls194_mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } seq_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous byte buffer with flush.
// The head entry is presented combinationally so the sequencer can load it on the same edge it pops.
module byte_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // Overflow/underflow requests are ignored rather than corrupting the pointers.
  assign push_ok = push_i & ~full_o & ~flush_i;
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ls194_load_sequencer.sv
// Feeds buffered video bytes into a downstream ls194 shift chain, LSB-first, DOTS dots per byte.
// Mode selects are decoded from registered state so the chain samples them on the edge we advance.
module ls194_load_sequencer
  import video_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DOTS       = DEF_DOTS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  Clk,
  input  logic                  clear,
  input  logic                  dot_en,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] p,
  output logic                  s1,
  output logic                  s0,
  output logic                  SLSI,
  output logic                  SRSI,
  output logic                  busy,
  output logic                  underrun
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] LAST_DOT = CW'(DOTS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  seq_state_e            state_q, state_d;
  logic [CW-1:0]         dot_cnt_q, dot_cnt_d;
  ls194_mode_e           mode;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;

  byte_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (Clk),
    .rst_n   (clear),
    .flush_i (flush),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (in_data),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign in_ready  = ~fifo_full;
  assign fifo_push = in_valid & in_ready & ~flush;

  always_comb begin
    state_d   = state_q;
    dot_cnt_d = dot_cnt_q;
    mode      = MODE_HOLD;
    p         = '0;
    fifo_pop  = 1'b0;
    underrun  = 1'b0;
    if (flush) begin
      state_d   = IDLE;
      dot_cnt_d = '0;
      if (dot_en) mode = MODE_LOAD;
    end else if (dot_en) begin
      case (state_q)
        IDLE: begin
          // Loading zeros while idle keeps the chain blank.
          mode = MODE_LOAD;
          if (!fifo_empty) begin
            p         = fifo_head;
            fifo_pop  = 1'b1;
            dot_cnt_d = '0;
            state_d   = SHIFT;
          end
        end
        SHIFT: begin
          if (dot_cnt_q < LAST_DOT) begin
            mode      = MODE_SHR;
            dot_cnt_d = dot_cnt_q + CNT_ONE;
          end else begin
            mode      = MODE_LOAD;
            dot_cnt_d = '0;
            if (!fifo_empty) begin
              p        = fifo_head;
              fifo_pop = 1'b1;
            end else begin
              underrun = 1'b1;
              state_d  = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge clear) begin
    if (!clear) begin
      state_q   <= IDLE;
      dot_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      dot_cnt_q <= dot_cnt_d;
    end
  end

  assign {s1, s0} = mode;
  assign SLSI     = 1'b0;
  assign SRSI     = 1'b0;
  assign busy     = (state_q == SHIFT);

endmodule

// File: tb/tb_ls194_load_sequencer.sv
// Drives two sequencers (DOTS=7 and DOTS=8) into modelled cascaded 4-bit ls194 pairs
// and checks handshake, mode outputs and the serial dot stream at chain bit0.
module tb_ls194_load_sequencer;

  logic       Clk = 1'b0;
  logic       clear, dot_en, flush, in_valid;
  logic [7:0] in_data;

  logic       rdy7, s1_7, s0_7, slsi7, srsi7, busy7, und7;
  logic [7:0] p7;
  logic       rdy8, s1_8, s0_8, slsi8, srsi8, busy8, und8;
  logic [7:0] p8;

  logic [3:0] hi7, lo7, hi8, lo8;

  always #5 Clk = ~Clk;

  ls194_load_sequencer #(.DATA_WIDTH(8), .DOTS(7), .FIFO_DEPTH(2)) dut7 (
    .Clk(Clk), .clear(clear), .dot_en(dot_en), .flush(flush), .in_valid(in_valid),
    .in_data(in_data), .in_ready(rdy7), .p(p7), .s1(s1_7), .s0(s0_7), .SLSI(slsi7),
    .SRSI(srsi7), .busy(busy7), .underrun(und7));

  ls194_load_sequencer #(.DATA_WIDTH(8), .DOTS(8), .FIFO_DEPTH(2)) dut8 (
    .Clk(Clk), .clear(clear), .dot_en(dot_en), .flush(flush), .in_valid(in_valid),
    .in_data(in_data), .in_ready(rdy8), .p(p8), .s1(s1_8), .s0(s0_8), .SLSI(slsi8),
    .SRSI(srsi8), .busy(busy8), .underrun(und8));

  // Two cascaded ls194s; not reset, so blanking must come from the sequencer itself.
  always @(posedge Clk) begin
    case ({s1_7, s0_7})
      2'b11: {hi7, lo7} <= p7;
      2'b10: begin hi7 <= {slsi7, hi7[3:1]}; lo7 <= {hi7[0], lo7[3:1]}; end
      2'b01: begin hi7 <= {hi7[2:0], lo7[3]}; lo7 <= {lo7[2:0], srsi7}; end
      default: ;
    endcase
    case ({s1_8, s0_8})
      2'b11: {hi8, lo8} <= p8;
      2'b10: begin hi8 <= {slsi8, hi8[3:1]}; lo8 <= {hi8[0], lo8[3:1]}; end
      2'b01: begin hi8 <= {hi8[2:0], lo8[3]}; lo8 <= {lo8[2:0], srsi8}; end
      default: ;
    endcase
  end

  typedef struct {
    logic       de;
    logic       fl;
    logic       v;
    logic [7:0] d;
    logic       rdy;
    logic       bsy;
    logic       und;
    logic [1:0] mode;
    logic [7:0] p;
  } vec_t;

  vec_t vecs[16];

  int errors = 0;
  int checks = 0;

  logic        s_b7, s_b8, s_u7, s_u8, s_rdy, s_busy;
  logic [1:0]  s_mode;
  logic [7:0]  s_p;
  logic [63:0] dots7, dots8, unds7, unds8;
  logic [7:0]  feed_q[$];

  function automatic vec_t mk(logic de, logic fl, logic v, logic [7:0] d, logic rdy,
                              logic bsy, logic und, logic [1:0] mode, logic [7:0] p);
    vec_t t;
    t.de = de; t.fl = fl; t.v = v; t.d = d; t.rdy = rdy;
    t.bsy = bsy; t.und = und; t.mode = mode; t.p = p;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: inputs applied after the previous edge, outputs sampled on the falling edge.
  task automatic cyc(input logic de, input logic fl, input logic v, input logic [7:0] d);
    dot_en = de; flush = fl; in_valid = v; in_data = d;
    @(negedge Clk);
    s_b7 = lo7[0]; s_b8 = lo8[0]; s_u7 = und7; s_u8 = und8;
    s_rdy = rdy7; s_busy = busy7; s_mode = {s1_7, s0_7}; s_p = p7;
    @(posedge Clk);
    #1;
    dot_en = 1'b0; flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic fcyc(input logic de, input logic fl);
    logic       v;
    logic [7:0] d;
    v = (feed_q.size() != 0);
    d = v ? feed_q[0] : 8'h00;
    cyc(de, fl, v, d);
    if (v && s_rdy && !fl) d = feed_q.pop_front();
    if (de) begin
      dots7 = {dots7[62:0], s_b7}; unds7 = {unds7[62:0], s_u7};
      dots8 = {dots8[62:0], s_b8}; unds8 = {unds8[62:0], s_u8};
    end
  endtask

  task automatic run(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      fcyc(1'b1, 1'b0);
      for (int g = 0; g < gap; g++) fcyc(1'b0, 1'b0);
    end
  endtask

  task automatic clr_rec();
    dots7 = '0; dots8 = '0; unds7 = '0; unds8 = '0;
  endtask

  task automatic do_reset();
    clear = 1'b0;
    feed_q.delete();
    repeat (2) @(posedge Clk);
    #1 clear = 1'b1;
    clr_rec();
  endtask

  initial begin
    clear = 1'b0; dot_en = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    vecs[0]  = mk(0, 0, 1, 8'hA1, 1, 0, 0, 2'b00, 8'h00);
    vecs[1]  = mk(0, 0, 1, 8'hB2, 1, 0, 0, 2'b00, 8'h00);
    vecs[2]  = mk(0, 0, 1, 8'hC3, 0, 0, 0, 2'b00, 8'h00);
    vecs[3]  = mk(1, 0, 0, 8'h00, 0, 0, 0, 2'b11, 8'hA1);
    vecs[4]  = mk(0, 0, 0, 8'h00, 1, 1, 0, 2'b00, 8'h00);
    vecs[5]  = mk(1, 0, 1, 8'hC3, 1, 1, 0, 2'b10, 8'h00);
    for (int i = 6; i <= 10; i++) vecs[i] = mk(1, 0, 0, 8'h00, 0, 1, 0, 2'b10, 8'h00);
    vecs[11] = mk(1, 0, 1, 8'hD4, 0, 1, 0, 2'b11, 8'hB2);
    vecs[12] = mk(0, 0, 0, 8'h00, 1, 1, 0, 2'b00, 8'h00);
    vecs[13] = mk(1, 1, 1, 8'hE5, 1, 1, 0, 2'b11, 8'h00);
    vecs[14] = mk(0, 0, 0, 8'h00, 1, 0, 0, 2'b00, 8'h00);
    vecs[15] = mk(1, 0, 0, 8'h00, 1, 0, 0, 2'b11, 8'h00);

    do_reset();
    check("reset_ready", 32'(rdy7), 32'd1);
    check("reset_busy", 32'(busy7), 32'd0);
    check("reset_underrun", 32'(und7), 32'd0);

    // Fill while idle, gapless reload with full buffer, flush mid-byte.
    for (int i = 0; i < 16; i++) begin
      cyc(vecs[i].de, vecs[i].fl, vecs[i].v, vecs[i].d);
      $display("vec %0d: de=%0b fl=%0b v=%0b d=%h -> rdy=%0b busy=%0b und=%0b mode=%b p=%h",
               i, vecs[i].de, vecs[i].fl, vecs[i].v, vecs[i].d, s_rdy, s_busy, s_u7, s_mode, s_p);
      check($sformatf("vec%0d_ready", i), 32'(s_rdy), 32'(vecs[i].rdy));
      check($sformatf("vec%0d_busy", i), 32'(s_busy), 32'(vecs[i].bsy));
      check($sformatf("vec%0d_underrun", i), 32'(s_u7), 32'(vecs[i].und));
      check($sformatf("vec%0d_mode", i), 32'(s_mode), 32'(vecs[i].mode));
      check($sformatf("vec%0d_p", i), 32'(s_p), 32'(vecs[i].p));
    end

    // Single byte, dot_en every second cycle.
    do_reset();
    feed_q.push_back(8'h5B);
    fcyc(1'b0, 1'b0);
    clr_rec();
    run(9, 1);
    $display("single 5B: dots=%b und=%b", dots7[8:0], unds7[8:0]);
    check("single_dots", 32'(dots7[8:0]), 32'(9'b0_1101101_0));
    check("single_underrun", 32'(unds7[8:0]), 32'(9'b0_0000001_0));

    // Three bytes streamed back-to-back.
    do_reset();
    feed_q.push_back(8'hFF); feed_q.push_back(8'h00); feed_q.push_back(8'hAA);
    repeat (3) fcyc(1'b0, 1'b0);
    check("prefill_ready", 32'(rdy7), 32'd0);
    clr_rec();
    run(23, 0);
    $display("stream: dots=%b und=%b", dots7[22:0], unds7[22:0]);
    check("stream_dots", 32'(dots7[22:0]), 32'(23'b0_1111111_0000000_0101010_0));
    check("stream_underrun", 32'(unds7[22:0]), 32'(23'b0_0000000_0000000_0000001_0));

    // Asynchronous clear in the middle of a byte.
    do_reset();
    feed_q.push_back(8'hFF);
    fcyc(1'b0, 1'b0);
    run(3, 0);
    check("midbyte_busy_pre", 32'(busy7), 32'd1);
    #2 clear = 1'b0;
    #1;
    $display("clear mid-byte: rdy=%0b busy=%0b und=%0b", rdy7, busy7, und7);
    check("clear_ready", 32'(rdy7), 32'd1);
    check("clear_busy", 32'(busy7), 32'd0);
    check("clear_underrun", 32'(und7), 32'd0);
    @(posedge Clk);
    #1 clear = 1'b1;
    clr_rec();
    run(2, 0);
    check("clear_chain_blank", 32'(dots7[1:0]), 32'(2'b10));
    check("clear_idle", 32'(s_busy), 32'd0);

    // Flush at dot 3 of 7F with a second byte queued.
    do_reset();
    feed_q.push_back(8'h7F); feed_q.push_back(8'h33);
    repeat (2) fcyc(1'b0, 1'b0);
    clr_rec();
    run(3, 0);
    fcyc(1'b1, 1'b1);
    $display("flush dot: mode=%b p=%h und=%0b", s_mode, s_p, s_u7);
    check("flush_mode", 32'(s_mode), 32'(2'b11));
    check("flush_p", 32'(s_p), 32'd0);
    fcyc(1'b0, 1'b0);
    check("flush_busy", 32'(s_busy), 32'd0);
    check("flush_ready", 32'(s_rdy), 32'd1);
    run(3, 0);
    $display("flush: dots=%b und=%b", dots7[6:0], unds7[6:0]);
    check("flush_dots", 32'(dots7[6:0]), 32'(7'b011_1_000));
    check("flush_underrun", 32'(unds7[6:0]), 32'd0);
    check("flush_fifo_empty", 32'(s_busy), 32'd0);

    // Eight dots per byte exposes the MSB.
    do_reset();
    feed_q.push_back(8'h80);
    fcyc(1'b0, 1'b0);
    clr_rec();
    run(10, 0);
    $display("dots8 80: dots=%b und=%b", dots8[9:0], unds8[9:0]);
    check("dots8_dots", 32'(dots8[9:0]), 32'(10'b0_00000001_0));
    check("dots8_underrun", 32'(unds8[9:0]), 32'(10'b0_00000001_0));
    check("dots7_msb_hidden", 32'(dots7[9:0]), 32'(10'b0_0000000_00));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
